product_byte_reader: RTL
========================

Name: product_byte_reader

Overview:
- Read-side companion to the 16-bit product register in the sequential 8x8 multiplier.
- Captures a completed 16-bit product on a load strobe.
- Emits the product as two 8-bit bytes over a valid/ready stream toward a byte-wide consumer (UART/display/host bus).
- Uses the same clock-enable and synchronous-clear semantics as the datapath registers, so it can sit directly beside them.

Parameters:
- MSB_FIRST, 0, 0: low byte sent first; 1: high byte sent first.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- aclr_n  input  1  asynchronous active-low reset; forces the reset state immediately, independent of clk.
- sclr_n  input  1  synchronous active-low clear; honoured only when clk_ena=1.
- clk_ena  input  1  clock enable; 0 = all state holds.
- load  input  1  capture request for datain.
- datain  input  16  product word to be read out.
- load_ready  output  1  high when a load will be accepted.
- out_data  output  8  current byte.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts byte.
- out_last  output  1  marks the second (final) byte of a word.
- busy  output  1  word in flight.

Behaviour:
- Reset/clock domain: one clock; reset asynchronous, active-low (aclr_n).

Reset (aclr_n=0):
- state=IDLE, shadow=16'd0, out_data=8'd0.
- out_valid=0, out_last=0, busy=0, load_ready=1.

States:
- IDLE, BYTE0, BYTE1.
- All outputs are registered except load_ready, which is decoded from state: 1 only in IDLE.

Event definitions:
- Enabled edge: rising clk with clk_ena=1.
- Transfer: out_valid & out_ready on an enabled edge.

Priority on an enabled edge:
1. sclr_n=0
2. load / transfer

sclr_n=0 with clk_ena=1:
- Next state IDLE; shadow, out_data, out_valid, out_last, busy all cleared, even mid-word.
- Undelivered bytes are dropped; a load in the same cycle is ignored.

sclr_n=0 with clk_ena=0:
- No effect.

clk_ena=0:
- All registers hold.
- out_valid and out_data stay stable.
- load and out_ready are ignored.

IDLE:
- load=1 → shadow<=datain; state<=BYTE0; out_valid<=1; busy<=1; out_last<=0.
- out_data<=datain[7:0], or datain[15:8] if MSB_FIRST=1.
- Output becomes visible the edge after load, so latency is 1 cycle.

BYTE0:
- Holds while out_ready=0; out_data must not change while out_valid=1 and the transfer is pending.
- On transfer → BYTE1; out_data<=the other byte of shadow; out_last<=1; out_valid stays 1.

BYTE1:
- On transfer → IDLE; out_valid<=0; out_last<=0; busy<=0.
- out_data holds its last value.

Load outside IDLE:
- Ignored; load_ready=0 there. The producer must hold load until it sees load_ready.

Throughput:
- Minimum 3 cycles per word (load, byte0, byte1), since load is not accepted on the BYTE1 completion edge.
- Back-to-back words therefore have a 1-cycle bubble.

Other rules:
- No arithmetic; pure byte-slicing of the captured shadow.
- datain changing after capture has no effect on the bytes in flight.
- aclr_n asserted mid-word: same outcome as reset; deassertion is synchronous to clk externally.

Test Plan:
1. Basic read-out:
   - Stimulus: MSB_FIRST=0, out_ready=1, load with datain=16'hA55A.
   - Required: next cycle out_data=8'h5A, out_valid=1, out_last=0; following cycle 8'hA5 with out_last=1; then out_valid=0, busy=0, load_ready=1.
2. Backpressure:
   - Stimulus: load 16'h1234, out_ready=0 for 5 cycles, then 1.
   - Required: out_data held at 8'h34 with out_valid=1 for all 5 cycles; then 8'h12 with out_last=1; change datain to 16'hFFFF after capture and verify no effect.
3. MSB_FIRST=1:
   - Stimulus: load 16'hBEEF.
   - Required: bytes 8'hBE then 8'hEF; out_last on 8'hEF.
4. Clock-enable gating:
   - Stimulus: in BYTE0 with out_ready=1, clk_ena=0 for 3 cycles; also pulse load and sclr_n=0 during that window.
   - Required: state, out_data and out_valid unchanged; resumes normally when clk_ena=1.
5. Sync clear mid-word:
   - Stimulus: load 16'hC3C3; in BYTE1, sclr_n=0 with clk_ena=1 and load=1.
   - Required: next cycle out_valid=0, out_data=0, busy=0, load_ready=1; the load is not captured.
6. Async reset mid-word:
   - Stimulus: assert aclr_n=0 between clock edges during BYTE0.
   - Required: outputs go to reset values without a clk edge; after release, load 16'h0001 yields 8'h01 then 8'h00.
   - Back-to-back loads held high produce a 1-cycle bubble (3-cycle spacing).

Source files
------------

// File: rtl/product_byte_reader_if.sv
// Byte read-out bus of the product reader: capture handshake from the
// multiplier side plus the valid/ready byte stream toward the consumer.
interface product_byte_reader_if;
    logic        load;
    logic [15:0] datain;
    logic        load_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;

    // master: producer/consumer environment; slave: the reader itself
    modport master (
        output load, datain, out_ready,
        input  load_ready, out_data, out_valid, out_last, busy
    );

    modport slave (
        input  load, datain, out_ready,
        output load_ready, out_data, out_valid, out_last, busy
    );
endinterface

// File: rtl/product_byte_reader.sv
// Captures a 16-bit product on load and streams it out as two bytes,
// sharing clock-enable / sync-clear semantics with the datapath registers.
module product_byte_reader #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                        clk,
    input  logic                        aclr_n,
    input  logic                        sclr_n,
    input  logic                        clk_ena,
    product_byte_reader_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BYTE0 = 2'd1,
        BYTE1 = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] shadow, shadow_nxt;
    logic [7:0]  data_q, data_nxt;
    logic        valid_q, valid_nxt;
    logic        last_q, last_nxt;
    logic        busy_q, busy_nxt;

    logic [7:0]  first_byte;
    logic [7:0]  second_byte;
    logic        xfer;

    // first byte comes straight from datain so it is visible one edge after load;
    // second byte comes from the shadow so later datain changes cannot leak in
    assign first_byte  = MSB_FIRST ? bus.datain[15:8] : bus.datain[7:0];
    assign second_byte = MSB_FIRST ? shadow[7:0]      : shadow[15:8];
    assign xfer        = valid_q & bus.out_ready;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state   <= IDLE;
            shadow  <= 16'd0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else if (clk_ena) begin
            state   <= state_nxt;
            shadow  <= shadow_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
            last_q  <= last_nxt;
            busy_q  <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        data_nxt   = data_q;
        valid_nxt  = valid_q;
        last_nxt   = last_q;
        busy_nxt   = busy_q;

        if (!sclr_n) begin
            // clear wins over everything, dropping any bytes still in flight
            state_nxt  = IDLE;
            shadow_nxt = 16'd0;
            data_nxt   = 8'd0;
            valid_nxt  = 1'b0;
            last_nxt   = 1'b0;
            busy_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        state_nxt  = BYTE0;
                        shadow_nxt = bus.datain;
                        data_nxt   = first_byte;
                        valid_nxt  = 1'b1;
                        last_nxt   = 1'b0;
                        busy_nxt   = 1'b1;
                    end
                end
                BYTE0: begin
                    if (xfer) begin
                        state_nxt = BYTE1;
                        data_nxt  = second_byte;
                        last_nxt  = 1'b1;
                    end
                end
                BYTE1: begin
                    // load is not accepted here, hence the one-cycle bubble
                    if (xfer) begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                        last_nxt  = 1'b0;
                        busy_nxt  = 1'b0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                    last_nxt  = 1'b0;
                    busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign bus.load_ready = (state == IDLE);
    assign bus.out_data   = data_q;
    assign bus.out_valid  = valid_q;
    assign bus.out_last   = last_q;
    assign bus.busy       = busy_q;

endmodule
